// File: rtl/memoria_dados_resp_if.sv
// Load/store request interface between the processor control FSM (master)
// and the data-memory responder (slave).
//   req  : request valid, held by the initiator until ack
//   we   : 1 = store, 0 = load
//   endr : byte address
//   din  : store data
//   dout : load data, valid with ack and held afterwards
//   ack  : one-cycle completion pulse
//   erro : request rejected, valid with ack
//   busy : transaction in progress
interface memoria_dados_resp_if #(
  parameter int unsigned LARGURA = 64
);
  logic               req;
  logic               we;
  logic [63:0]        endr;
  logic [LARGURA-1:0] din;
  logic [LARGURA-1:0] dout;
  logic               ack;
  logic               erro;
  logic               busy;

  modport master (
    output req, we, endr, din,
    input  dout, ack, erro, busy
  );

  modport slave (
    input  req, we, endr, din,
    output dout, ack, erro, busy
  );
endinterface

// File: rtl/memoria_dados_resp.sv
// Data-memory responder with fixed latency.
// Accepts one load/store of a 64-bit word at a time, waits LATENCIA cycles
// and returns a one-cycle ack, with load data on dout or erro for a
// misaligned / out-of-range address.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (also clears the memory)
//   bus   : slave side of memoria_dados_resp_if (req/we/endr/din in,
//           dout/ack/erro/busy out)
module memoria_dados_resp #(
  parameter int unsigned LATENCIA     = 2,
  parameter int unsigned PROFUNDIDADE = 32,
  parameter int unsigned LARGURA      = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  memoria_dados_resp_if.slave  bus
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ESPERA   = 2'd1,
    RESPONDE = 2'd2
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [4:0]         idx_q, idx_d;
  logic [LARGURA-1:0] din_q, din_d;
  logic               err_q, err_d;
  logic               ack_q, ack_d;
  logic               erro_q, erro_d;
  logic               busy_q, busy_d;
  logic [LARGURA-1:0] dout_q, dout_d;
  logic               mem_we;
  logic [LARGURA-1:0] mem_q [PROFUNDIDADE];

  assign bus.ack  = ack_q;
  assign bus.erro = erro_q;
  assign bus.busy = busy_q;
  assign bus.dout = dout_q;

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    idx_d    = idx_q;
    din_d    = din_q;
    err_d    = err_q;
    ack_d    = 1'b0;
    erro_d   = 1'b0;
    busy_d   = busy_q;
    dout_d   = dout_q;
    mem_we   = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (bus.req) begin
          we_d     = bus.we;
          idx_d    = bus.endr[7:3];
          din_d    = bus.din;
          // Address is validated once at acceptance; the wait still runs in full.
          err_d    = (bus.endr[2:0] != '0) || (bus.endr[63:8] != '0);
          cnt_d    = 4'(LATENCIA - 1);
          busy_d   = 1'b1;
          estado_d = ESPERA;
        end
      end
      ESPERA: begin
        if (cnt_q == '0) begin
          estado_d = RESPONDE;
          ack_d    = 1'b1;
          erro_d   = err_q;
          if (!err_q) begin
            if (we_q) mem_we = 1'b1;
            else      dout_d = mem_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPONDE: begin
        // req is deliberately not sampled here.
        busy_d   = 1'b0;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      din_q    <= '0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      erro_q   <= 1'b0;
      busy_q   <= 1'b0;
      dout_q   <= '0;
      for (int unsigned i = 0; i < PROFUNDIDADE; i++) mem_q[i] <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      din_q    <= din_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      erro_q   <= erro_d;
      busy_q   <= busy_d;
      dout_q   <= dout_d;
      if (mem_we) mem_q[idx_q] <= din_q;
    end
  end

endmodule

// File: tb/tb_memoria_dados_resp.sv
// Directed bench for memoria_dados_resp: one instance with LATENCIA=2 and
// one with LATENCIA=3, sharing clock and reset.
module tb_memoria_dados_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  memoria_dados_resp_if #(.LARGURA(64)) b2 ();
  memoria_dados_resp_if #(.LARGURA(64)) b3 ();

  memoria_dados_resp #(.LATENCIA(2), .PROFUNDIDADE(32), .LARGURA(64)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );
  memoria_dados_resp #(.LATENCIA(3), .PROFUNDIDADE(32), .LARGURA(64)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );

  // Index 0 drives the LATENCIA=2 instance, index 1 the LATENCIA=3 one.
  logic        req_v  [2];
  logic        we_v   [2];
  logic [63:0] endr_v [2];
  logic [63:0] din_v  [2];
  logic        ack_s  [2];
  logic        erro_s [2];
  logic        busy_s [2];
  logic [63:0] dout_s [2];

  assign b2.req  = req_v[0];
  assign b2.we   = we_v[0];
  assign b2.endr = endr_v[0];
  assign b2.din  = din_v[0];
  assign b3.req  = req_v[1];
  assign b3.we   = we_v[1];
  assign b3.endr = endr_v[1];
  assign b3.din  = din_v[1];
  assign ack_s[0]  = b2.ack;
  assign ack_s[1]  = b3.ack;
  assign erro_s[0] = b2.erro;
  assign erro_s[1] = b3.erro;
  assign busy_s[0] = b2.busy;
  assign busy_s[1] = b3.busy;
  assign dout_s[0] = b2.dout;
  assign dout_s[1] = b3.dout;

  // Issues one request and waits (bounded) for ack. lat is the number of
  // edges from acceptance to the ack edge, -1 on timeout.
  task automatic transacao(input int s, input logic w, input logic [63:0] a,
                           input logic [63:0] d, output int lat,
                           output logic e, output logic [63:0] q,
                           output logic busy_ok);
    lat = -1; e = 1'b0; q = '0; busy_ok = 1'b1;
    @(negedge clk);
    we_v[s] = w; endr_v[s] = a; din_v[s] = d; req_v[s] = 1'b1;
    @(posedge clk); #1;
    if (busy_s[s] !== 1'b1) busy_ok = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (busy_s[s] !== 1'b1) busy_ok = 1'b0;
      if (ack_s[s] === 1'b1) begin
        lat = c; e = erro_s[s]; q = dout_s[s];
        break;
      end
    end
    @(negedge clk);
    req_v[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_v[s] = 1'b0; we_v[s] = 1'b0; endr_v[s] = '0; din_v[s] = '0;
    end
    #2 rst_n = 1'b0;
    #1;  // before any clock edge: reset must already have acted
    for (int s = 0; s < 2; s++) begin
      tests_run++;
      if ({ack_s[s], erro_s[s], busy_s[s]} !== 3'b000 || dout_s[s] !== 64'h0) begin
        tests_failed++;
        $display("FAIL reset_async[%0d]: ack/erro/busy=%b%b%b dout=%h expected 000 dout=0",
                 s, ack_s[s], erro_s[s], busy_s[s], dout_s[s]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (ack_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: ack=%b busy=%b expected 0 0", ack_s[0], busy_s[0]);
    end
  endtask

  task automatic test_store_load();
    int lat; logic e, bok; logic [63:0] q;
    transacao(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, lat, e, q, bok);
    tests_run++;
    if (lat !== 2 || e !== 1'b0 || q !== 64'h0) begin
      tests_failed++;
      $display("FAIL store_10: lat=%0d erro=%b dout=%h expected 2 0 0", lat, e, q);
    end
    transacao(0, 1'b0, 64'h10, 64'h0, lat, e, q, bok);
    tests_run++;
    if (lat !== 2 || e !== 1'b0 || q !== 64'hDEADBEEF_CAFEF00D) begin
      tests_failed++;
      $display("FAIL load_10: lat=%0d erro=%b dout=%h expected 2 0 deadbeefcafef00d", lat, e, q);
    end
    @(posedge clk); #1;
    tests_run++;
    if (ack_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_pulse: ack=%b busy=%b expected 0 0", ack_s[0], busy_s[0]);
    end
  endtask

  task automatic test_latencia3();
    int lat; logic e, bok; logic [63:0] q;
    transacao(1, 1'b1, 64'hF8, 64'h1, lat, e, q, bok);
    tests_run++;
    if (lat !== 3 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL l3_store: lat=%0d erro=%b expected 3 0", lat, e);
    end
    transacao(1, 1'b0, 64'hF8, 64'h0, lat, e, q, bok);
    tests_run++;
    if (lat !== 3 || e !== 1'b0 || q !== 64'h1) begin
      tests_failed++;
      $display("FAIL l3_load: lat=%0d erro=%b dout=%h expected 3 0 1", lat, e, q);
    end
    tests_run++;
    if (bok !== 1'b1) begin
      tests_failed++;
      $display("FAIL l3_busy: busy_held=%b expected 1", bok);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy_s[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL l3_busy_drop: busy=%b expected 0", busy_s[1]);
    end
  endtask

  task automatic test_desalinhado();
    int lat; logic e, bok; logic [63:0] q;
    transacao(0, 1'b1, 64'h08, 64'hAAAA, lat, e, q, bok);
    transacao(0, 1'b1, 64'h0C, 64'h55, lat, e, q, bok);
    tests_run++;
    if (lat !== 2 || e !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned: lat=%0d erro=%b expected 2 1", lat, e);
    end
    @(posedge clk); #1;
    tests_run++;
    if (erro_s[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL erro_clear: erro=%b expected 0", erro_s[0]);
    end
    transacao(0, 1'b0, 64'h08, 64'h0, lat, e, q, bok);
    tests_run++;
    if (e !== 1'b0 || q !== 64'hAAAA) begin
      tests_failed++;
      $display("FAIL no_write_on_err: erro=%b dout=%h expected 0 aaaa", e, q);
    end
  endtask

  task automatic test_fora_faixa();
    int lat; logic e, bok; logic [63:0] q;
    transacao(0, 1'b0, 64'h100, 64'h0, lat, e, q, bok);
    tests_run++;
    if (lat !== 2 || e !== 1'b1 || q !== 64'hAAAA) begin
      tests_failed++;
      $display("FAIL out_of_range_100: lat=%0d erro=%b dout=%h expected 2 1 aaaa", lat, e, q);
    end
    transacao(0, 1'b0, 64'h8000_0000_0000_0010, 64'h0, lat, e, q, bok);
    tests_run++;
    if (e !== 1'b1 || q !== 64'hAAAA) begin
      tests_failed++;
      $display("FAIL out_of_range_msb: erro=%b dout=%h expected 1 aaaa", e, q);
    end
  endtask

  task automatic test_back_to_back();
    int nacks = 0, t1 = -1, t2 = -1;
    logic [63:0] d1 = '0, d2 = '0;
    @(negedge clk);
    we_v[0] = 1'b0; endr_v[0] = 64'h10; req_v[0] = 1'b1;
    @(posedge clk);  // acceptance edge N
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) endr_v[0] = 64'h08;  // changed while busy
      if (ack_s[0] === 1'b1) begin
        nacks++;
        if (nacks == 1) begin t1 = c; d1 = dout_s[0]; end
        else begin t2 = c; d2 = dout_s[0]; end
      end
      if (c == 6) req_v[0] = 1'b0;
    end
    tests_run++;
    if (nacks !== 2 || t1 !== 2 || t2 !== 6) begin
      tests_failed++;
      $display("FAIL b2b_timing: acks=%0d at %0d,%0d expected 2 at 2,6", nacks, t1, t2);
    end
    tests_run++;
    if (d1 !== 64'hDEADBEEF_CAFEF00D || d2 !== 64'hAAAA) begin
      tests_failed++;
      $display("FAIL b2b_data: %h,%h expected deadbeefcafef00d,aaaa", d1, d2);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic e, bok; logic [63:0] q;
    int seen = 0;
    @(negedge clk);
    we_v[0] = 1'b1; endr_v[0] = 64'h20; din_v[0] = 64'h77; req_v[0] = 1'b1;
    @(posedge clk);  // acceptance
    @(posedge clk); #1;
    rst_n = 1'b0; req_v[0] = 1'b0;
    #1;
    tests_run++;
    if (busy_s[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_busy: busy=%b expected 0", busy_s[0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (ack_s[0] !== 1'b0) seen++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (ack_s[0] !== 1'b0) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_ack: ack samples high=%0d expected 0", seen);
    end
    transacao(0, 1'b0, 64'h20, 64'h0, lat, e, q, bok);
    tests_run++;
    if (lat !== 2 || e !== 1'b0 || q !== 64'h0) begin
      tests_failed++;
      $display("FAIL abort_no_write: lat=%0d erro=%b dout=%h expected 2 0 0", lat, e, q);
    end
    transacao(0, 1'b0, 64'h10, 64'h0, lat, e, q, bok);
    tests_run++;
    if (q !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_clears_mem: dout=%h expected 0", q);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy_s[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL final_busy: busy=%b expected 0", busy_s[0]);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_latencia3();
    test_desalinhado();
    test_fora_faixa();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
